// File: rtl/gpio_data_in_reg.sv
// GPIO DATA_IN capture with per-bit change interrupts behind a one-entry valid/ready register port.
// Optional macro GPIO_DATA_IN_INTR_EN builds INTR_STATE/INTR_ENABLE and intr_o; otherwise only DATA_IN exists.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_IDLE  | no response held; a request is accepted
// ST_RSP   | response held until rsp_ready_i consumes it
module gpio_data_in_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [32:0] hw2reg_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [3:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        intr_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] data_in_q, data_in_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_valid;
    logic        accept, consume;
    logic        addr_aligned, sel_data, sel_state, sel_en;
    logic        req_err;
    logic [31:0] read_data;
    logic [31:0] hw_d;
    logic        hw_de;
    logic [31:0] intr_state_val, intr_enable_val;

    assign hw_d  = hw2reg_i[32:1];
    assign hw_de = hw2reg_i[0];

    assign req_ready_o = ~rsp_valid | rsp_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign consume     = rsp_valid & rsp_ready_i;

    always_comb begin
        addr_aligned = (req_addr_i[1:0] == 2'b00);
        sel_data     = addr_aligned & (req_addr_i[3:2] == 2'd0);
        sel_state    = addr_aligned & (req_addr_i[3:2] == 2'd1);
        sel_en       = addr_aligned & (req_addr_i[3:2] == 2'd2);
`ifdef GPIO_DATA_IN_INTR_EN
        req_err      = ~((sel_data & ~req_we_i) | sel_state | sel_en);
`else
        req_err      = ~(sel_data & ~req_we_i);
`endif
        read_data = 32'h0;
        if (!req_we_i && !req_err) begin
            if (sel_data)       read_data = data_in_q;
            else if (sel_state) read_data = intr_state_val;
            else if (sel_en)    read_data = intr_enable_val;
        end
    end

    always_comb begin
        data_in_d   = hw_de ? hw_d : data_in_q;
        rsp_rdata_d = accept ? read_data : rsp_rdata_q;
        rsp_err_d   = accept ? req_err : rsp_err_q;
    end

`ifdef GPIO_DATA_IN_INTR_EN
    logic [31:0] intr_state_q, intr_state_d;
    logic [31:0] intr_enable_q, intr_enable_d;
    logic [31:0] intr_set, intr_clr;

    // Set is OR'd in after the clear so a same-cycle change wins over W1C.
    always_comb begin
        intr_set      = hw_de ? (hw_d ^ data_in_q) : 32'h0;
        intr_clr      = (accept & req_we_i & sel_state) ? req_wdata_i : 32'h0;
        intr_state_d  = (intr_state_q & ~intr_clr) | intr_set;
        intr_enable_d = (accept & req_we_i & sel_en) ? req_wdata_i : intr_enable_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            intr_state_q  <= 32'h0;
            intr_enable_q <= 32'h0;
        end else begin
            intr_state_q  <= intr_state_d;
            intr_enable_q <= intr_enable_d;
        end
    end

    assign intr_state_val  = intr_state_q;
    assign intr_enable_val = intr_enable_q;
    assign intr_o          = |(intr_state_q & intr_enable_q);
`else
    logic unused_wdata;

    assign unused_wdata    = ^req_wdata_i;
    assign intr_state_val  = 32'h0;
    assign intr_enable_val = 32'h0;
    assign intr_o          = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_in_q   <= RESET_VAL;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            data_in_q   <= data_in_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RSP;
            ST_RSP:  if (consume && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q == ST_RSP);
    end

    assign rsp_valid_o = rsp_valid;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/gpio_data_in_reg.md
# gpio_data_in_reg

Register-side consumer of the GPIO `hw2reg.data_in` field. It captures the 32-bit input value whenever hardware asserts `de`, and flags per-bit changes in a W1C interrupt-state register. It exposes DATA_IN, INTR_STATE and INTR_ENABLE through a single-outstanding valid/ready register port. It sits between the GPIO input sampler, which drives `gpio_hw2reg_t`, and the bus adapter.

## Interface
- `RESET_VAL`, default 32'h0: reset value of the DATA_IN register.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `hw2reg_i`  in  33  packed `gpio_hw2reg_t`:
  - [32:1] = `data_in.d`.
  - [0] = `data_in.de`.
- `req_valid_i`  in  1  register request valid.
- `req_ready_o`  out  1  request accepted when valid & ready.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  4  byte address.
- `req_wdata_i`  in  32  write data.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed when valid & ready.
- `rsp_rdata_o`  out  32  read data; 0 for writes and errors.
- `rsp_err_o`  out  1  error response.
- `intr_o`  out  1  level interrupt.

## Operation
- Register map:
  - 0x0 DATA_IN: read-only.
  - 0x4 INTR_STATE: W1C.
  - 0x8 INTR_ENABLE: read/write.
  - 0xC: unmapped.
- Any of the following returns `rsp_err_o`=1, `rsp_rdata_o`=0, with no state change:
  - `req_addr_i[1:0]` != 0;
  - address 0xC;
  - a write to DATA_IN.
- Capture: on a cycle with `de`=1:
  - `data_in_q` <= `d`;
  - `intr_state_q` |= (`d` ^ `data_in_q`).
  - With `de`=0, both registers hold.
- INTR_STATE write: `intr_state_q` &= ~`wdata`.
  - Set has priority over clear per bit: a bit that changes on the same cycle as a W1C of that bit ends at 1.
- INTR_ENABLE write: `intr_enable_q` <= `wdata`.
- `intr_o` = |(`intr_state_q` & `intr_enable_q`). It is combinational from flops only.
- Reads sample register values as they were before the accept edge. A read accepted on the same edge as a capture returns the old value.
- Response buffer is one entry:
  - `req_ready_o` = ~`rsp_valid_o` | `rsp_ready_i`.
  - `rsp_valid_o`, `rsp_rdata_o` and `rsp_err_o` stay stable while `rsp_valid_o`=1 and `rsp_ready_i`=0.
- Back-to-back: a response consumed on edge N allows a new request to be accepted on that same edge; its response is valid after edge N.
- States are IDLE (no response held) and RSP (response held):
  - IDLE -> RSP on accept.
  - RSP -> IDLE on consume with no new accept.
  - RSP -> RSP on consume with a simultaneous accept.
- Reset values:
  - `data_in_q` = `RESET_VAL`.
  - `intr_state_q` = 0, `intr_enable_q` = 0.
  - `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_err_o` = 0.
  - `req_ready_o` = 1, `intr_o` = 0.
- Reset asserted with a response pending drops the response; no handshake completes on that edge.
- Change detection after reset compares against `RESET_VAL`.

## Timing
- Capture latency is 1 cycle: `de` sampled at edge N makes DATA_IN and INTR_STATE visible after edge N.
- `intr_o` rises in the cycle after edge N when the corresponding enable bit is set.
- Request-to-response latency is 1 cycle. Response throughput is 1 per cycle while `rsp_ready_i` is held at 1.
- W1C takes effect at the accept edge; `intr_o` deasserts in the following cycle if no other enabled bit is set.
- `hw2reg_i` is sampled only at clock edges. There is no combinational path from `hw2reg_i` to any output.

## Configuration
- Macro: `GPIO_DATA_IN_INTR_EN`.
- Defined: behaviour as specified above.
- Undefined:
  - no INTR_STATE or INTR_ENABLE flops are built;
  - addresses 0x4 and 0x8 return error like 0xC;
  - `intr_o` is tied to 0;
  - DATA_IN capture and the register port are unchanged.

## Test plan
- Reset, then read 0x0 with `RESET_VAL`=0 -> `rsp_rdata_o`=0, `rsp_err_o`=0; `intr_o`=0.
- Drive `d`=32'hA5A5_0001, `de`=1 for one cycle, then `de`=0 with `d`=32'hFFFF_FFFF; read 0x0 -> 32'hA5A5_0001; read 0x4 -> 32'hA5A5_0001.
- Write 0x8=32'h0000_0001 -> `intr_o`=1 next cycle; write 0x4=32'h0000_0001 -> `intr_o`=0 next cycle; read 0x4 -> 32'hA5A5_0000.
- W1C 0x4 bit 4 on the same edge that `de`=1 toggles bit 4 -> bit 4 reads 1 afterwards.
- Accept a read, hold `rsp_ready_i`=0 for 3 cycles -> `req_ready_o`=0 and the response is stable throughout; set `rsp_ready_i`=1 with a new read pending -> accepted that edge, next response valid next cycle.
- Write to 0x0, read 0xC, read 0x2 -> each returns `rsp_err_o`=1, `rdata`=0, DATA_IN unchanged. With the macro undefined, read 0x4 -> `rsp_err_o`=1 and `intr_o` stays 0.
